// File: rtl/y_stamp_engine_pkg.sv
// Shared FSM states, op-sign encoding and slot helpers for the Y-matrix stamp engine.
package y_stamp_pkg;

  localparam int HALF_W_DEF = 24;
  localparam int ELEM_W_DEF = 2 * HALF_W_DEF;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    RDW  = 3'd2,
    ADD  = 3'd3,
    WR   = 3'd4
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int unsigned slotOffset(input int unsigned slot, input int unsigned elemW);
    return slot * elemW;
  endfunction

endpackage

// File: rtl/y_stamp_engine_if.sv
// Change-entry stream, Y-memory ports and FP adder link of the stamp engine.
interface y_stamp_engine_if #(
  parameter int IDX_W  = 16,
  parameter int HALF_W = 24,
  parameter int ROW_W  = 256,
  parameter int ADDR_W = 11
);
  localparam int ELEM_W = 2 * HALF_W;

  logic              chg_valid;
  logic              chg_ready;
  logic [IDX_W-1:0]  chg_row;
  logic [IDX_W-1:0]  chg_col;
  logic [HALF_W-1:0] chg_real;
  logic [HALF_W-1:0] chg_img;
  logic              chg_sym;
  logic [ADDR_W-1:0] sram_raddr;
  logic [ROW_W-1:0]  sram_rdata;
  logic [ADDR_W-1:0] sram_waddr;
  logic [ROW_W-1:0]  sram_wdata;
  logic              sram_we;
  logic [ELEM_W-1:0] fp_in1;
  logic [ELEM_W-1:0] fp_in2;
  logic              fp_mode;
  logic [ELEM_W-1:0] fp_out;
  logic [ELEM_W-1:0] op_yval;
  logic              busy;
  logic              done;
  logic              err;

  // The engine is the master of the memory and adder links.
  modport master (
    input  chg_valid, chg_row, chg_col, chg_real, chg_img, chg_sym, sram_rdata, fp_out,
    output chg_ready, sram_raddr, sram_waddr, sram_wdata, sram_we,
           fp_in1, fp_in2, fp_mode, op_yval, busy, done, err
  );

  modport slave (
    output chg_valid, chg_row, chg_col, chg_real, chg_img, chg_sym, sram_rdata, fp_out,
    input  chg_ready, sram_raddr, sram_waddr, sram_wdata, sram_we,
           fp_in1, fp_in2, fp_mode, op_yval, busy, done, err
  );
endinterface

// File: rtl/y_stamp_engine_addr_map.sv
// Maps a (row, col) element to its SRAM row address and slot, and flags out-of-range indices.
module y_addr_map #(
  parameter int N_DIM  = 64,
  parameter int IDX_W  = 16,
  parameter int EPR    = 4,
  parameter int ADDR_W = 11,
  parameter int SLOT_W = 2
) (
  input  logic [IDX_W-1:0]  i_row,
  input  logic [IDX_W-1:0]  i_col,
  output logic [ADDR_W-1:0] o_addr,
  output logic [SLOT_W-1:0] o_slot,
  output logic              o_inRange
);

  logic [31:0] w_idx;

  assign w_idx     = 32'(i_row) * 32'(N_DIM) + 32'(i_col);
  assign o_addr    = ADDR_W'(w_idx / 32'(EPR));
  assign o_slot    = SLOT_W'(w_idx % 32'(EPR));
  assign o_inRange = (32'(i_row) < 32'(N_DIM)) && (32'(i_col) < 32'(N_DIM));

endmodule

// File: rtl/y_stamp_engine.sv
// Y-matrix read-modify-write engine: applies single adds or four-point branch stamps
// through the shared external FP adder, one element update at a time.
module y_stamp_engine
  import y_stamp_pkg::*;
#(
  parameter int N_DIM  = 64,
  parameter int IDX_W  = 16,
  parameter int HALF_W = 24,
  parameter int ELEM_W = 48,
  parameter int EPR    = 4,
  parameter int ROW_W  = 256,
  parameter int ADDR_W = 11,
  parameter int FP_LAT = 2
) (
  input logic               clock,
  input logic               reset,
  y_stamp_engine_if.master  bus
);

  localparam int SLOT_W = (EPR > 1) ? $clog2(EPR) : 1;
  localparam int CNT_W  = $clog2(FP_LAT + 1);
  localparam int OFF_W  = $clog2(ROW_W);

  state_e            r_state;
  logic [IDX_W-1:0]  r_row;
  logic [IDX_W-1:0]  r_col;
  logic [ELEM_W-1:0] r_delta;
  logic              r_sym;
  logic [1:0]        r_opIdx;
  logic [1:0]        r_lastOp;
  logic [CNT_W-1:0]  r_addCnt;
  logic [ROW_W-1:0]  r_rowBuf;
  logic [ROW_W-1:0]  r_wdata;
  logic [ELEM_W-1:0] r_fpIn1;
  logic [ELEM_W-1:0] r_fpIn2;
  logic              r_fpMode;
  logic [ELEM_W-1:0] r_sum;
  logic [ELEM_W-1:0] r_yval;
  logic [ADDR_W-1:0] r_raddr;
  logic [ADDR_W-1:0] r_waddr;
  logic              r_ready;
  logic              r_done;
  logic              r_err;

  logic [IDX_W-1:0]  w_opRow;
  logic [IDX_W-1:0]  w_opCol;
  logic              w_opSub;
  logic [IDX_W-1:0]  w_mapRow;
  logic [IDX_W-1:0]  w_mapCol;
  logic [ADDR_W-1:0] w_addr;
  logic [SLOT_W-1:0] w_slot;
  logic [OFF_W-1:0]  w_off;
  logic              w_inRange;
  logic              w_accept;
  logic              w_lastAdd;

  // Stamp order: (r,r,+) (c,c,+) (r,c,-) (c,r,-); a plain entry is just (r,c,+).
  always_comb begin
    w_opRow = r_row;
    w_opCol = r_col;
    w_opSub = OP_ADD;
    if (r_sym) begin
      case (r_opIdx)
        2'd0:    w_opCol = r_row;
        2'd1:    w_opRow = r_col;
        2'd2:    w_opSub = OP_SUB;
        default: begin
          w_opRow = r_col;
          w_opCol = r_row;
          w_opSub = OP_SUB;
        end
      endcase
    end
  end

  // While idle the mapper looks at the incoming entry so the range check happens at accept.
  assign w_mapRow  = (r_state == IDLE) ? bus.chg_row : w_opRow;
  assign w_mapCol  = (r_state == IDLE) ? bus.chg_col : w_opCol;
  assign w_off     = OFF_W'(slotOffset(32'(w_slot), ELEM_W));
  assign w_accept  = bus.chg_valid && r_ready && (r_state == IDLE);
  assign w_lastAdd = (r_addCnt == CNT_W'(FP_LAT - 1));

  y_addr_map #(
    .N_DIM (N_DIM),
    .IDX_W (IDX_W),
    .EPR   (EPR),
    .ADDR_W(ADDR_W),
    .SLOT_W(SLOT_W)
  ) u_addrMap (
    .i_row    (w_mapRow),
    .i_col    (w_mapCol),
    .o_addr   (w_addr),
    .o_slot   (w_slot),
    .o_inRange(w_inRange)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_row    <= '0;
      r_col    <= '0;
      r_delta  <= '0;
      r_sym    <= 1'b0;
      r_opIdx  <= '0;
      r_lastOp <= '0;
      r_addCnt <= '0;
      r_rowBuf <= '0;
      r_wdata  <= '0;
      r_fpIn1  <= '0;
      r_fpIn2  <= '0;
      r_fpMode <= OP_ADD;
      r_sum    <= '0;
      r_yval   <= '0;
      r_raddr  <= '0;
      r_waddr  <= '0;
      r_ready  <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          r_ready <= 1'b1;
          if (w_accept && w_inRange) begin
            r_row    <= bus.chg_row;
            r_col    <= bus.chg_col;
            r_delta  <= {bus.chg_real, bus.chg_img};
            r_sym    <= bus.chg_sym;
            r_opIdx  <= '0;
            r_lastOp <= (bus.chg_sym && (bus.chg_row != bus.chg_col)) ? 2'd3 : 2'd0;
            r_ready  <= 1'b0;
            r_state  <= RD;
          end else if (w_accept) begin
            r_err <= 1'b1;
          end
        end
        RD: begin
          r_raddr <= w_addr;
          r_state <= RDW;
        end
        RDW: begin
          r_rowBuf <= bus.sram_rdata;
          r_fpIn1  <= bus.sram_rdata[w_off +: ELEM_W];
          r_fpIn2  <= r_delta;
          r_fpMode <= w_opSub;
          r_addCnt <= '0;
          r_state  <= ADD;
        end
        ADD: begin
          if (w_lastAdd) begin
            r_sum                    <= bus.fp_out;
            r_wdata                  <= r_rowBuf;
            r_wdata[w_off +: ELEM_W] <= bus.fp_out;
            r_waddr                  <= w_addr;
            r_state                  <= WR;
          end else begin
            r_addCnt <= r_addCnt + 1'b1;
          end
        end
        WR: begin
          r_yval <= r_sum;
          if (r_opIdx == r_lastOp) begin
            r_ready <= 1'b1;
            r_done  <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_opIdx <= r_opIdx + 1'b1;
            r_state <= RD;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.chg_ready  = r_ready;
  assign bus.sram_raddr = (r_state == RD) ? w_addr : r_raddr;
  assign bus.sram_waddr = r_waddr;
  assign bus.sram_wdata = r_wdata;
  assign bus.sram_we    = (r_state == WR);
  assign bus.fp_in1     = r_fpIn1;
  assign bus.fp_in2     = r_fpIn2;
  assign bus.fp_mode    = r_fpMode;
  assign bus.op_yval    = r_yval;
  assign bus.busy       = (r_state != IDLE);
  assign bus.done       = r_done;
  assign bus.err        = r_err;

endmodule

// File: tb/tb_y_stamp_engine.sv
// Directed bench for y_stamp_engine with an SRAM/adder environment and an element-level Y model.
module tb_y_stamp_engine;
  import y_stamp_pkg::*;

  localparam int N_DIM  = 64;
  localparam int IDX_W  = 16;
  localparam int HALF_W = 24;
  localparam int ELEM_W = 48;
  localparam int EPR    = 4;
  localparam int ROW_W  = 256;
  localparam int ADDR_W = 11;
  localparam int FP_LAT = 2;
  localparam int DEPTH  = N_DIM * N_DIM / EPR;

  typedef struct {
    int                row;
    int                col;
    logic              sub;
    logic [ELEM_W-1:0] delta;
  } op_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   nChecks = 0;
  int   nErrors = 0;

  logic [ROW_W-1:0]  mem    [DEPTH];
  logic [ROW_W-1:0]  expMem [DEPTH];
  op_t               opQ[$];
  logic              yvalPending = 1'b0;
  logic [ELEM_W-1:0] yvalExp;

  always #5 clock = ~clock;

  y_stamp_engine_if #(.IDX_W(IDX_W), .HALF_W(HALF_W), .ROW_W(ROW_W), .ADDR_W(ADDR_W)) bus ();

  y_stamp_engine #(
    .N_DIM(N_DIM), .IDX_W(IDX_W), .HALF_W(HALF_W), .ELEM_W(ELEM_W),
    .EPR(EPR), .ROW_W(ROW_W), .ADDR_W(ADDR_W), .FP_LAT(FP_LAT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  // Integer adder standing in for fp_dw: per-component wrap-around add/subtract.
  function automatic logic [ELEM_W-1:0] fpModel(input logic [ELEM_W-1:0] a, input logic [ELEM_W-1:0] b,
                                                input logic sub);
    logic [HALF_W-1:0] re;
    logic [HALF_W-1:0] im;
    re = sub ? a[ELEM_W-1:HALF_W] - b[ELEM_W-1:HALF_W] : a[ELEM_W-1:HALF_W] + b[ELEM_W-1:HALF_W];
    im = sub ? a[HALF_W-1:0] - b[HALF_W-1:0] : a[HALF_W-1:0] + b[HALF_W-1:0];
    return {re, im};
  endfunction

  // Synchronous SRAM (one-cycle read) and a FP_LAT=2 adder: one register stage after constant inputs.
  always @(posedge clock) begin
    if (bus.sram_we) mem[bus.sram_waddr] <= bus.sram_wdata;
    bus.sram_rdata <= mem[bus.sram_raddr];
    bus.fp_out     <= fpModel(bus.fp_in1, bus.fp_in2, bus.fp_mode);
  end

  task automatic checkOutput(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every write is matched against the next pending element update applied to the Y model.
  always @(negedge clock) begin : scoreboard
    op_t               op;
    int                idx;
    int                s;
    logic [ADDR_W-1:0] a;
    logic [ELEM_W-1:0] old;
    logic [ELEM_W-1:0] newv;
    logic [ROW_W-1:0]  mask;
    if (yvalPending) begin
      checkOutput("op_yval", 256'(bus.op_yval), 256'(yvalExp));
      yvalPending = 1'b0;
    end
    if (bus.sram_we) begin
      if (opQ.size() == 0) begin
        checkOutput("unexpected_write", 256'(bus.sram_we), 256'(0));
      end else begin
        op   = opQ.pop_front();
        idx  = op.row * N_DIM + op.col;
        a    = ADDR_W'(idx / EPR);
        s    = idx % EPR;
        old  = ELEM_W'(expMem[a] >> (s * ELEM_W));
        newv = fpModel(old, op.delta, op.sub);
        mask = ROW_W'({ELEM_W{1'b1}}) << (s * ELEM_W);
        expMem[a] = (expMem[a] & ~mask) | (ROW_W'(newv) << (s * ELEM_W));
        checkOutput("waddr", 256'(bus.sram_waddr), 256'(a));
        checkOutput("wdata", bus.sram_wdata, expMem[a]);
        checkOutput("fp_mode", 256'(bus.fp_mode), 256'(op.sub));
        checkOutput("fp_in1", 256'(bus.fp_in1), 256'(old));
        checkOutput("fp_in2", 256'(bus.fp_in2), 256'(op.delta));
        yvalExp     = newv;
        yvalPending = 1'b1;
      end
    end
  end

  task automatic pushOp(input int row, input int col, input logic sub, input logic [ELEM_W-1:0] d);
    op_t op;
    op.row = row; op.col = col; op.sub = sub; op.delta = d;
    opQ.push_back(op);
  endtask

  task automatic launch(input int row, input int col, input logic [HALF_W-1:0] re,
                        input logic [HALF_W-1:0] im, input logic sym);
    int w = 0;
    while (!bus.chg_ready && w < 50) begin
      @(negedge clock);
      w++;
    end
    checkOutput("ready_wait", 256'(bus.chg_ready), 256'(1));
    bus.chg_row   = IDX_W'(row);
    bus.chg_col   = IDX_W'(col);
    bus.chg_real  = re;
    bus.chg_img   = im;
    bus.chg_sym   = sym;
    bus.chg_valid = 1'b1;
    @(posedge clock);
    #1;
    bus.chg_valid = 1'b0;
    if (row < N_DIM && col < N_DIM) begin
      if (!sym || row == col) begin
        pushOp(row, col, 1'b0, {re, im});
      end else begin
        pushOp(row, row, 1'b0, {re, im});
        pushOp(col, col, 1'b0, {re, im});
        pushOp(row, col, 1'b1, {re, im});
        pushOp(col, row, 1'b1, {re, im});
      end
    end
  endtask

  task automatic waitDone(output int cycles, output logic gotDone, output logic gotErr);
    cycles = 0; gotDone = 1'b0; gotErr = 1'b0;
    while (!gotDone && !gotErr && cycles < 100) begin
      @(negedge clock);
      cycles++;
      gotDone = bus.done;
      gotErr  = bus.err;
    end
    checkOutput("completion", 256'(gotDone | gotErr), 256'(1));
  endtask

  task automatic applyStimulus(input string tag, input int row, input int col, input logic [HALF_W-1:0] re,
                               input logic [HALF_W-1:0] im, input logic sym, input int expCycles,
                               input logic expErr);
    int   cycles;
    logic gotDone;
    logic gotErr;
    launch(row, col, re, im, sym);
    waitDone(cycles, gotDone, gotErr);
    checkOutput({tag, "_cycles"}, 256'(cycles), 256'(expCycles));
    checkOutput({tag, "_err"}, 256'(gotErr), 256'(expErr));
    checkOutput({tag, "_ready"}, 256'(bus.chg_ready), 256'(1));
    checkOutput({tag, "_busy"}, 256'(bus.busy), 256'(0));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_wdata"}, bus.sram_wdata, '0);
    checkOutput({tag, "_misc"},
                256'({bus.sram_raddr, bus.sram_waddr, bus.fp_in1, bus.fp_in2, bus.fp_mode, bus.op_yval,
                      bus.busy, bus.done, bus.err, bus.sram_we, bus.chg_ready}), '0);
  endtask

  initial begin
    logic [31:0] p;
    logic        quiet;
    for (int a = 0; a < DEPTH; a++) begin
      p = 32'(a) * 32'h9E37_79B1;
      mem[a] = {8{p}};
    end
    mem[49][95:48]   = {24'd100, 24'd50};
    mem[112][143:96] = {24'd30, 24'd9};
    mem[0][47:0]     = '0;
    for (int a = 0; a < DEPTH; a++) expMem[a] = mem[a];

    bus.chg_valid = 1'b0;
    bus.chg_row   = '0;
    bus.chg_col   = '0;
    bus.chg_real  = '0;
    bus.chg_img   = '0;
    bus.chg_sym   = 1'b0;

    repeat (3) @(negedge clock);
    checkAllZero("reset");
    reset = 1'b1;
    @(negedge clock);
    checkOutput("ready_after_reset", 256'(bus.chg_ready), 256'(1));

    applyStimulus("single", 3, 5, 24'd5, 24'd3, 1'b0, 6, 1'b0);
    checkOutput("single_yval_lit", 256'(bus.op_yval), 256'(48'h000069_000035));
    checkOutput("single_mem_lit", 256'(mem[49][95:48]), 256'(48'h000069_000035));

    applyStimulus("stamp", 2, 7, 24'd10, 24'd4, 1'b1, 21, 1'b0);
    checkOutput("stamp_yval_lit", 256'(bus.op_yval), 256'(48'h000014_000005));

    applyStimulus("diag", 10, 10, 24'd1, 24'd1, 1'b1, 6, 1'b0);

    applyStimulus("oor_row", 64, 0, 24'd1, 24'd1, 1'b0, 1, 1'b1);
    applyStimulus("oor_col", 0, 64, 24'd1, 24'd1, 1'b1, 1, 1'b1);
    applyStimulus("oor_max", 16'hFFFF, 3, 24'd1, 24'd1, 1'b0, 1, 1'b1);
    quiet = 1'b0;
    repeat (8) begin
      @(negedge clock);
      if (bus.done || bus.sram_we || bus.busy) quiet = 1'b1;
    end
    checkOutput("oor_no_activity", 256'(quiet), 256'(0));

    applyStimulus("accum1", 0, 0, 24'd1, 24'd0, 1'b0, 6, 1'b0);
    applyStimulus("accum2", 0, 0, 24'd1, 24'd0, 1'b0, 6, 1'b0);
    checkOutput("accum_yval_lit", 256'(bus.op_yval), 256'(48'h000002_000000));

    // Abort a stamp in the first ADD cycle of its third op (cycle 13 after accept).
    launch(20, 30, 24'd3, 24'd3, 1'b1);
    repeat (13) @(negedge clock);
    checkOutput("pre_reset_busy", 256'(bus.busy), 256'(1));
    checkOutput("pre_reset_mode", 256'(bus.fp_mode), 256'(1));
    reset = 1'b0;
    #1;
    checkAllZero("mid_reset");
    checkOutput("writes_left", 256'(opQ.size()), 256'(2));
    opQ.delete();
    yvalPending = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    #1;
    checkOutput("ready_at_release", 256'(bus.chg_ready), 256'(0));
    @(negedge clock);
    checkOutput("ready_after_release", 256'(bus.chg_ready), 256'(1));

    applyStimulus("post_reset", 20, 20, 24'd1, 24'd2, 1'b0, 6, 1'b0);
    applyStimulus("post_reset_uncommitted", 30, 20, 24'd7, 24'd8, 1'b0, 6, 1'b0);
    repeat (2) @(negedge clock);
    checkOutput("queue_empty", 256'(opQ.size()), 256'(0));

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
